// File: rtl/i2c_slave_pkg.sv
// i2c_slave_pkg: FSM encoding, bus constants and pointer helper shared by the I2C target.
package i2c_slave_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK,
    S_IGNORE
  } state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam int BITS_PER_BYTE = 8;

  function automatic logic [4:0] ptr_wrap(input logic [4:0] ptr, input logic [4:0] n);
    return (ptr >= n - 5'd1) ? 5'd0 : ptr + 5'd1;
  endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// i2c_bus_monitor: synchronises SCL/SDA and reports SCL edges plus START/STOP conditions.
// Defining I2C_GLITCH_FILTER_EN inserts a 3-sample majority filter after the synchronisers.
module i2c_bus_monitor #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_c;
  logic                   sda_c;
  logic                   scl_d;
  logic                   sda_d;

  // Idle bus level is high, so flops reset high to avoid a phantom edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [2:0] scl_f;
  logic [2:0] sda_f;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_f <= '1;
      sda_f <= '1;
    end else begin
      scl_f <= {scl_f[1:0], scl_sync[SYNC_STAGES-1]};
      sda_f <= {sda_f[1:0], sda_sync[SYNC_STAGES-1]};
    end
  end

  assign scl_c = (scl_f[0] & scl_f[1]) | (scl_f[0] & scl_f[2]) | (scl_f[1] & scl_f[2]);
  assign sda_c = (sda_f[0] & sda_f[1]) | (sda_f[0] & sda_f[2]) | (sda_f[1] & sda_f[2]);
`else
  assign scl_c = scl_sync[SYNC_STAGES-1];
  assign sda_c = sda_sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_c;
      sda_d <= sda_c;
    end
  end

  assign scl_rise  = scl_c & ~scl_d;
  assign scl_fall  = ~scl_c & scl_d;
  assign sda_s     = sda_c;
  assign start_det = scl_c & scl_d & sda_d & ~sda_c;
  assign stop_det  = scl_c & scl_d & ~sda_d & sda_c;

endmodule

// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: oversampled I2C target with pointer, auto-increment, reads and N_REGS registers.
// Build option I2C_GLITCH_FILTER_EN enables the input majority filter in i2c_bus_monitor.
//
// state     | meaning
// IDLE      | bus free, waiting for START
// ADDR      | shifting target address + R/W
// ADDR_ACK  | driving ACK for matched address
// PTR       | shifting register pointer byte
// PTR_ACK   | driving ACK for pointer byte
// WDATA     | shifting write data byte
// WDATA_ACK | driving ACK for write data
// RDATA     | driving read data bits on SCL falls
// RDATA_ACK | sampling controller ACK/NACK
// IGNORE    | not addressed / read ended, wait for START or STOP
module i2c_slave_regfile
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR    = 7'h2A,
  parameter int         N_REGS      = 8,
  parameter int         SYNC_STAGES = 2,
  localparam int        PTR_W       = $clog2(N_REGS)
) (
  input  logic                clk,
  input  logic                i2c_rst,
  input  logic                scl_in,
  input  logic                sda_in,
  output logic                sda_oe,
  output logic [8*N_REGS-1:0] regs_flat,
  output logic                wr_stb,
  output logic [PTR_W-1:0]    wr_addr,
  output logic                busy
);

  logic scl_rise, scl_fall, sda_s, start_det, stop_det;

  i2c_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_mon (
    .clk       (clk),
    .rst       (i2c_rst),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .sda_s     (sda_s),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_t           state, state_nx;
  logic [3:0]       cnt, cnt_nx;
  logic [7:0]       sh, sh_nx;
  logic [PTR_W-1:0] ptr, ptr_nx, ptr_inc;
  logic             oe_nx, busy_nx, wr_en, last_bit;
  logic [7:0]       rx_byte;
  logic [7:0]       regs [N_REGS];

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sh_nx    = sh;
    ptr_nx   = ptr;
    oe_nx    = sda_oe;
    busy_nx  = busy;
    wr_en    = 1'b0;
    rx_byte  = {sh[6:0], sda_s};
    last_bit = (cnt == 4'(BITS_PER_BYTE - 1));
    ptr_inc  = PTR_W'(ptr_wrap(5'(ptr), 5'(N_REGS)));
    if (stop_det) begin
      state_nx = S_IDLE;
      oe_nx    = 1'b0;
      busy_nx  = 1'b0;
    end else if (start_det) begin
      state_nx = S_ADDR;
      cnt_nx   = '0;
      oe_nx    = 1'b0;
    end else begin
      case (state)
        S_ADDR: if (scl_rise) begin
          sh_nx  = rx_byte;
          cnt_nx = cnt + 4'd1;
          if (last_bit) begin
            cnt_nx = '0;
            if (rx_byte[7:1] == I2C_ADDR) begin
              state_nx = S_ADDR_ACK;
              busy_nx  = 1'b1;
            end else begin
              state_nx = S_IGNORE;
              busy_nx  = 1'b0;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) oe_nx = ~ACK;
          else if (scl_rise) begin
            // sh[0] still holds the R/W bit of the address byte
            if (sh[0]) begin
              sh_nx    = regs[ptr];
              state_nx = S_RDATA;
            end else begin
              state_nx = S_PTR;
            end
          end
        end
        S_PTR, S_WDATA: begin
          if (scl_fall) oe_nx = 1'b0;
          else if (scl_rise) begin
            sh_nx  = rx_byte;
            cnt_nx = cnt + 4'd1;
            if (last_bit) begin
              cnt_nx = '0;
              if (state == S_PTR) begin
                ptr_nx   = rx_byte[PTR_W-1:0];
                state_nx = S_PTR_ACK;
              end else begin
                wr_en    = 1'b1;
                ptr_nx   = ptr_inc;
                state_nx = S_WDATA_ACK;
              end
            end
          end
        end
        S_PTR_ACK, S_WDATA_ACK: begin
          if (scl_fall) oe_nx = ~ACK;
          else if (scl_rise) state_nx = S_WDATA;
        end
        S_RDATA: if (scl_fall) begin
          if (cnt == 4'(BITS_PER_BYTE)) begin
            oe_nx    = 1'b0;
            cnt_nx   = '0;
            state_nx = S_RDATA_ACK;
          end else begin
            oe_nx  = ~sh[7];
            sh_nx  = {sh[6:0], 1'b0};
            cnt_nx = cnt + 4'd1;
          end
        end
        S_RDATA_ACK: if (scl_rise) begin
          if (sda_s == ACK) begin
            ptr_nx   = ptr_inc;
            sh_nx    = regs[ptr_inc];
            state_nx = S_RDATA;
          end else begin
            state_nx = S_IGNORE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge i2c_rst) begin
    if (i2c_rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      sh      <= '0;
      ptr     <= '0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      sh     <= sh_nx;
      ptr    <= ptr_nx;
      sda_oe <= oe_nx;
      busy   <= busy_nx;
      wr_stb <= wr_en;
      if (wr_en) wr_addr <= ptr;
    end
  end

  always_ff @(posedge clk or posedge i2c_rst) begin
    if (i2c_rst) begin
      for (int k = 0; k < N_REGS; k++) regs[k] <= '0;
    end else if (wr_en) begin
      regs[ptr] <= rx_byte;
    end
  end

  for (genvar k = 0; k < N_REGS; k++) begin : g_flat
    assign regs_flat[8*k +: 8] = regs[k];
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// tb_i2c_slave_regfile: bit-banged I2C controller with a queue-based scoreboard for the register-file target.
module tb_i2c_slave_regfile;

  localparam int N_REGS = 8;
  localparam int PTR_W  = 3;
  localparam int Q      = 6;

  logic                clk = 1'b0;
  logic                i2c_rst = 1'b1;
  logic                scl_c = 1'b1;
  logic                sda_c = 1'b1;
  logic                scl_in, sda_in, sda_oe, wr_stb, busy;
  logic [8*N_REGS-1:0] regs_flat;
  logic [PTR_W-1:0]    wr_addr;

  assign scl_in = scl_c;
  assign sda_in = sda_c & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_regfile #(.I2C_ADDR(7'h2A), .N_REGS(N_REGS), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .i2c_rst   (i2c_rst),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda_oe    (sda_oe),
    .regs_flat (regs_flat),
    .wr_stb    (wr_stb),
    .wr_addr   (wr_addr),
    .busy      (busy)
  );

  typedef struct { int addr; logic [7:0] data; } wr_t;
  typedef struct { string name; logic [7:0] val; } bus_t;

  wr_t        wr_exp[$];
  bus_t       bus_exp[$];
  bus_t       bus_act[$];
  logic [7:0] shadow [N_REGS];
  int         errors = 0;
  int         checks = 0;
  int         start_cnt = 0;
  logic       oe_seen = 1'b0;
  logic       busy_seen = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] shadow_flat();
    logic [63:0] f;
    f = '0;
    for (int k = 0; k < N_REGS; k++) f[8*k +: 8] = shadow[k];
    return f;
  endfunction

  // Scoreboard monitor: write strobes and bus responses are matched against queued expectations.
  always @(negedge clk) begin
    wr_t  we;
    bus_t be, ba;
    if (start_cnt < 1000 && dut.u_mon.start_det) start_cnt++;
    if (sda_oe) oe_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
    if (wr_stb) begin
      if (wr_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_stb_unexpected actual=strobe(addr %0d) required=none", wr_addr);
      end else begin
        we = wr_exp.pop_front();
        check("wr_addr", 64'(wr_addr), 64'(we.addr));
        check("wr_data", 64'(regs_flat[8*we.addr +: 8]), 64'(we.data));
      end
    end
    while (bus_act.size() > 0 && bus_exp.size() > 0) begin
      ba = bus_act.pop_front();
      be = bus_exp.pop_front();
      check(be.name, 64'(ba.val), 64'(be.val));
    end
  end

  task automatic wq();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_c = 1'b1; wq();
    scl_c = 1'b1; wq();
    sda_c = 1'b0; wq();
    scl_c = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    sda_c = 1'b0; wq();
    scl_c = 1'b1; wq();
    sda_c = 1'b1; wq();
  endtask

  task automatic wbit(input logic b);
    sda_c = b; wq();
    scl_c = 1'b1; wq(); wq();
    scl_c = 1'b0; wq();
  endtask

  task automatic rbit(output logic b);
    sda_c = 1'b1; wq();
    scl_c = 1'b1; wq();
    b = sda_in; wq();
    scl_c = 1'b0; wq();
  endtask

  task automatic wbyte(input logic [7:0] d, input string nm, input logic exp_ack);
    logic a;
    bus_exp.push_back('{nm, {7'd0, exp_ack}});
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(a);
    bus_act.push_back('{nm, {7'd0, a}});
  endtask

  task automatic rbyte(input string nm, input logic [7:0] exp, input logic nack);
    logic [7:0] d;
    logic       b;
    bus_exp.push_back('{nm, exp});
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
    bus_act.push_back('{nm, d});
    wbit(nack);
  endtask

  task automatic exp_write(input int a, input logic [7:0] d);
    wr_exp.push_back('{a, d});
    shadow[a] = d;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic b;
    for (int k = 0; k < N_REGS; k++) shadow[k] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sda_oe", 64'(sda_oe), 64'd0);
    check("rst_regs", regs_flat, 64'd0);
    check("rst_wr_stb", 64'(wr_stb), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    i2c_rst = 1'b0;
    wq();

    // single write
    i2c_start();
    wbyte(8'h54, "w1_addr_ack", 1'b0);
    check("w1_busy_mid", 64'(busy), 64'd1);
    wbyte(8'h03, "w1_ptr_ack", 1'b0);
    exp_write(3, 8'hA5);
    wbyte(8'hA5, "w1_data_ack", 1'b0);
    i2c_stop();
    wq();
    check("w1_busy_after", 64'(busy), 64'd0);
    check("w1_regs", regs_flat, shadow_flat());

    // burst with pointer wrap
    i2c_start();
    wbyte(8'h54, "w2_addr_ack", 1'b0);
    wbyte(8'h06, "w2_ptr_ack", 1'b0);
    exp_write(6, 8'h11);
    wbyte(8'h11, "w2_d0_ack", 1'b0);
    exp_write(7, 8'h22);
    wbyte(8'h22, "w2_d1_ack", 1'b0);
    exp_write(0, 8'h33);
    wbyte(8'h33, "w2_d2_ack", 1'b0);
    i2c_stop();
    wq();
    check("w2_regs", regs_flat, shadow_flat());

    // seed reg4 so the second read byte is distinctive
    i2c_start();
    wbyte(8'h54, "w3_addr_ack", 1'b0);
    wbyte(8'h04, "w3_ptr_ack", 1'b0);
    exp_write(4, 8'h3C);
    wbyte(8'h3C, "w3_data_ack", 1'b0);
    i2c_stop();

    // read through repeated START
    i2c_start();
    wbyte(8'h54, "r_waddr_ack", 1'b0);
    wbyte(8'h03, "r_ptr_ack", 1'b0);
    i2c_start();
    wbyte(8'h55, "r_raddr_ack", 1'b0);
    rbyte("r_byte0", 8'hA5, 1'b0);
    rbyte("r_byte1", 8'h3C, 1'b1);
    wq();
    check("r_released", 64'(sda_oe), 64'd0);
    check("r_busy_ignore", 64'(busy), 64'd1);
    i2c_stop();
    wq();
    check("r_busy_after", 64'(busy), 64'd0);

    // wrong address
    oe_seen = 1'b0;
    busy_seen = 1'b0;
    i2c_start();
    wbyte(8'h56, "x_addr_nack", 1'b1);
    wbyte(8'hFF, "x_data_nack", 1'b1);
    i2c_stop();
    wq();
    check("x_oe_seen", 64'(oe_seen), 64'd0);
    check("x_busy_seen", 64'(busy_seen), 64'd0);
    check("x_regs", regs_flat, shadow_flat());

    // reset in the middle of a read byte (reg3 = A5: bits 7..4 = 1,0,1,0)
    i2c_start();
    wbyte(8'h54, "m_waddr_ack", 1'b0);
    wbyte(8'h03, "m_ptr_ack", 1'b0);
    i2c_start();
    wbyte(8'h55, "m_raddr_ack", 1'b0);
    rbit(b); check("m_bit7", 64'(b), 64'd1);
    rbit(b); check("m_bit6", 64'(b), 64'd0);
    rbit(b); check("m_bit5", 64'(b), 64'd1);
    check("m_oe_bit4", 64'(sda_oe), 64'd1);
    @(posedge clk);
    #3 i2c_rst = 1'b1;
    #1;
    check("m_oe_async", 64'(sda_oe), 64'd0);
    check("m_regs_clear", regs_flat, 64'd0);
    check("m_busy_clear", 64'(busy), 64'd0);
    for (int k = 0; k < N_REGS; k++) shadow[k] = 8'h00;
    repeat (2) @(posedge clk);
    #1 i2c_rst = 1'b0;
    scl_c = 1'b1;
    sda_c = 1'b1;
    wq(); wq();
    i2c_start();
    wbyte(8'h54, "m2_addr_ack", 1'b0);
    wbyte(8'h02, "m2_ptr_ack", 1'b0);
    exp_write(2, 8'h7E);
    wbyte(8'h7E, "m2_data_ack", 1'b0);
    i2c_stop();
    wq();
    check("m2_regs", regs_flat, 64'h0000_0000_007E_0000);

    // one-clock SDA glitch with SCL high
    wq();
    start_cnt = 0;
    @(posedge clk); #1 sda_c = 1'b0;
    @(posedge clk); #1 sda_c = 1'b1;
    repeat (20) @(posedge clk);
    #1;
`ifdef I2C_GLITCH_FILTER_EN
    check("g_start_count", 64'(start_cnt), 64'd0);
`else
    check("g_start_count", 64'(start_cnt), 64'd1);
`endif
    check("g_busy", 64'(busy), 64'd0);
    check("g_regs", regs_flat, shadow_flat());

    repeat (4) @(posedge clk);
    #1;
    check("wr_queue_drained", 64'(wr_exp.size()), 64'd0);
    check("bus_queue_drained", 64'(bus_exp.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regfile.md
Name: i2c_slave_regfile

Overview:
- Clock-oversampled I2C target with an 8-bit register file; successor to the asynchronous, SCL-clocked programming port.
- Sits behind the top-level SDA/SCL pins; exposes the registers to the core as a flat bus plus a per-write strobe.
- Generalised in target address, register count and synchroniser depth; adds register pointer, auto-increment, reads, repeated start and NACK handling.

Parameters:
- I2C_ADDR, 7'h2A, 7-bit target address matched after START.
- N_REGS, 8, number of 8-bit registers; power of two, 2..16.
- SYNC_STAGES, 2, flip-flop stages on the SDA and SCL inputs; at least 2.
- PTR_W, $clog2(N_REGS), register pointer width; derived, never overridden.

Ports:
- clk, in, 1, system clock; must be at least 16x the SCL frequency.
- i2c_rst, in, 1, asynchronous active-high reset.
- scl_in, in, 1, raw SCL pin.
- sda_in, in, 1, raw SDA pin.
- sda_oe, out, 1, 1 = pull SDA low (open-drain); 0 = release.
- regs_flat, out, 8*N_REGS, register contents; reg k occupies [8k+7:8k].
- wr_stb, out, 1, one-clk pulse when a register is written.
- wr_addr, out, PTR_W, index of the register just written.
- busy, out, 1, high from address match until STOP, or until the next START that does not match.

Behaviour:
- Reset: sda_oe=0, regs_flat=0, wr_stb=0, wr_addr=0, busy=0, pointer=0, FSM=IDLE. Asserting i2c_rst mid-transfer releases SDA immediately.
- Input conditioning:
  - SCL and SDA pass through SYNC_STAGES flops, then one history flop.
  - Edges are detected on the synchronised values.
  - START = SDA falling while SCL high; STOP = SDA rising while SCL high.
- Timing rules:
  - Bits are sampled on a synchronised SCL rising edge.
  - sda_oe changes only on a synchronised SCL falling edge.
  - Resulting latency: SYNC_STAGES+1 clk after the pin edge.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- START from any state goes to ADDR (repeated START included); the bit counter clears and the pointer is kept.
- STOP from any state goes to IDLE; sda_oe=0 and busy=0.
- ADDR: shift 8 bits, MSB first.
  - [7:1]==I2C_ADDR: go to ADDR_ACK and drive ACK (sda_oe=1) for the 9th clock.
  - No match: go to IGNORE and never drive.
- After ADDR_ACK:
  - R/W=0: go to PTR.
  - R/W=1: load the shift register from reg[pointer], then go to RDATA.
- PTR: shift 8 bits; pointer = byte[PTR_W-1:0]; upper bits are discarded. ACK, then WDATA.
- WDATA: shift 8 bits; on the 8th rising edge:
  - reg[pointer] = byte;
  - wr_stb pulses 1 clk with wr_addr = pointer;
  - pointer increments modulo N_REGS (N_REGS-1 wraps to 0).
  - ACK, then WDATA again.
- RDATA: drive the inverted data bit on each falling edge (sda_oe = ~bit), MSB first. After 8 bits, release SDA and go to RDATA_ACK.
- RDATA_ACK: sample the controller ACK on the 9th rising edge.
  - ACK (0): pointer increments with wrap, reload the shift register, go to RDATA.
  - NACK (1): go to IGNORE, with SDA released.
- IGNORE: wait for START or STOP; sda_oe stays 0.
- A write and the increment in the same clk act on the old pointer.
- regs_flat updates the clk after the 8th data bit is sampled.

Optional Feature:
- Macro: I2C_GLITCH_FILTER_EN.
- Defined: each synchronised line feeds a 3-sample majority filter (3 shift flops); edge detection uses the filtered value, adding 2 clk latency. Pulses of at most 1 clk are suppressed.
- Undefined: synchroniser output is used directly; no added latency; single-clk glitches are seen as edges.

Decomposition:
- Package i2c_slave_pkg:
  - FSM state enum (4-bit) and the ACK/NACK constants;
  - BITS_PER_BYTE = 8;
  - function ptr_wrap(ptr, n).
- Sub-module i2c_bus_monitor:
  - synchronisers, optional glitch filter and edge detection;
  - outputs scl_rise, scl_fall, sda_s, start_det, stop_det.
- i2c_slave_regfile holds the FSM, shifter, pointer and register array.

Test Plan:
- Write: START, 0x54, ptr 0x03, data 0xA5, STOP -> ACK on all three bytes; reg3=0xA5; one wr_stb with wr_addr=3; busy low after STOP.
- Burst with wrap: ptr 0x06, data 0x11 0x22 0x33 -> reg6=0x11, reg7=0x22, reg0=0x33; three wr_stb pulses.
- Read with repeated START: write ptr 0x03, Sr, 0x55, controller ACKs byte 1 and NACKs byte 2 -> SDA returns 0xA5 then reg4; released after NACK.
- Wrong address: START, 0x56, data 0xFF -> sda_oe never asserted; regs unchanged; busy stays 0.
- Reset mid-read: assert i2c_rst while driving bit 4 of a read byte -> sda_oe=0 the same cycle; all regs 0; the next transaction works normally.
- Glitch (macro defined): 1-clk SDA low pulse while SCL high -> no START detected. Macro undefined: the same pulse produces start_det and the FSM goes to ADDR.
